// File: rtl/matrix_display_core.sv
// 8x8 bicolor LED matrix front end: three blink dividers, key debouncer, row-scan driver.
// Optional macro GHOST_BLANK_EN blanks the columns on the first cycle of every row slot.
`timescale 1ns/1ps
module matrix_display_core #(
    parameter int DIV_LOW     = 1000,
    parameter int DIV_MID     = 500,
    parameter int DIV_HIGH    = 250,
    parameter int DEB_CYCLES  = 20000,
    parameter int SCAN_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key,
    input  logic [63:0] picture_r,
    input  logic [63:0] picture_g,
    output logic        key_pulse,
    output logic        blink_low,
    output logic        blink_mid,
    output logic        blink_high,
    output logic [7:0]  row,
    output logic [7:0]  col_r,
    output logic [7:0]  col_g
);
    localparam int LW = $clog2(DIV_LOW);
    localparam int MW = $clog2(DIV_MID);
    localparam int HW = $clog2(DIV_HIGH);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int SW = $clog2(SCAN_CYCLES);

    logic [LW-1:0] low_cnt;
    logic [MW-1:0] mid_cnt;
    logic [HW-1:0] high_cnt;
    logic [DW-1:0] deb_cnt;
    logic [SW-1:0] scan_cnt;
    logic [2:0]    idx;
    logic          sync1, sync2, level, level_q;
    logic          blank;
    logic [5:0]    base;

    // Each divider counts half a period, then toggles its output.
    always_ff @(posedge clk) begin
        if (rst) begin
            low_cnt   <= '0;
            blink_low <= 1'b0;
        end else if (low_cnt == LW'(DIV_LOW / 2 - 1)) begin
            low_cnt   <= '0;
            blink_low <= ~blink_low;
        end else begin
            low_cnt <= low_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mid_cnt   <= '0;
            blink_mid <= 1'b0;
        end else if (mid_cnt == MW'(DIV_MID / 2 - 1)) begin
            mid_cnt   <= '0;
            blink_mid <= ~blink_mid;
        end else begin
            mid_cnt <= mid_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            high_cnt   <= '0;
            blink_high <= 1'b0;
        end else if (high_cnt == HW'(DIV_HIGH / 2 - 1)) begin
            high_cnt   <= '0;
            blink_high <= ~blink_high;
        end else begin
            high_cnt <= high_cnt + 1'b1;
        end
    end

    // The debounced level only follows the synchronized key after DEB_CYCLES
    // consecutive differing cycles; any bounce back restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            level     <= 1'b0;
            level_q   <= 1'b0;
            deb_cnt   <= '0;
            key_pulse <= 1'b0;
        end else begin
            sync1     <= key;
            sync2     <= sync1;
            level_q   <= level;
            key_pulse <= level & ~level_q;
            if (sync2 == level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
                level   <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

`ifdef GHOST_BLANK_EN
    assign blank = (scan_cnt == '0);
`else
    assign blank = 1'b0;
`endif

    // Row idx takes byte [63-8*idx -: 8]; its low bit position is 8*(7-idx).
    assign base = {~idx, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 3'd0;
            row      <= 8'hFF;
            col_r    <= 8'h00;
            col_g    <= 8'h00;
        end else begin
            if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            row   <= ~(8'b1 << idx);
            col_r <= blank ? 8'h00 : picture_r[base +: 8];
            col_g <= blank ? 8'h00 : picture_g[base +: 8];
        end
    end
endmodule

// File: tb/tb_matrix_display_core.sv
// Directed bench for matrix_display_core: blinks, debounce press/bounce/glitch, scan order,
// live picture update and reset mid-scan, all checked every cycle against hand-derived values.
`timescale 1ns/1ps
module tb_matrix_display_core;
    localparam int DL  = 8;
    localparam int DM  = 4;
    localparam int DH  = 2;
    localparam int DEB = 4;
    localparam int SC  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key = 1'b0;
    logic [63:0] pic_r;
    logic [63:0] pic_g;
    logic        key_pulse, blink_low, blink_mid, blink_high;
    logic [7:0]  row, col_r, col_g;

    int compared   = 0;
    int mismatched = 0;
    int n          = 0;   // edges since reset release
    int pulse_at   = -1;  // edge number at which key_pulse must be high

    matrix_display_core #(
        .DIV_LOW(DL), .DIV_MID(DM), .DIV_HIGH(DH),
        .DEB_CYCLES(DEB), .SCAN_CYCLES(SC)
    ) dut (
        .clk(clk), .rst(rst), .key(key),
        .picture_r(pic_r), .picture_g(pic_g),
        .key_pulse(key_pulse),
        .blink_low(blink_low), .blink_mid(blink_mid), .blink_high(blink_high),
        .row(row), .col_r(col_r), .col_g(col_g)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, n);
        end
    endtask

    // One clock edge, then check every output.
    task automatic step();
        logic        r;
        logic [63:0] pg;
        int          idx;
        logic [7:0]  erow, er, eg;
        r  = rst;
        pg = pic_g;
        @(posedge clk);
        #1;
        if (r) begin
            n = 0;
            check("rst_key_pulse", 8'(key_pulse), 8'h00);
            check("rst_blink_low", 8'(blink_low), 8'h00);
            check("rst_blink_mid", 8'(blink_mid), 8'h00);
            check("rst_blink_high", 8'(blink_high), 8'h00);
            check("rst_row", row, 8'hFF);
            check("rst_col_r", col_r, 8'h00);
            check("rst_col_g", col_g, 8'h00);
        end else begin
            n++;
            idx  = ((n - 1) / SC) % 8;
            erow = ~(8'h01 << idx);
            er   = 8'h01 << idx;  // picture_r is held at 64'h0102040810204080
            eg   = pg[63 - 8*idx -: 8];
`ifdef GHOST_BLANK_EN
            if ((n - 1) % SC == 0) begin
                er = 8'h00;
                eg = 8'h00;
            end
`endif
            check("blink_low", 8'(blink_low), 8'((n / (DL / 2)) % 2));
            check("blink_mid", 8'(blink_mid), 8'((n / (DM / 2)) % 2));
            check("blink_high", 8'(blink_high), 8'((n / (DH / 2)) % 2));
            check("row", row, erow);
            check("col_r", col_r, er);
            check("col_g", col_g, eg);
            check("key_pulse", 8'(key_pulse), 8'(n == pulse_at));
        end
    endtask

    initial begin
        int guard;
        pic_r = 64'h0102040810204080;
        pic_g = 64'h0;
        rst   = 1'b1;
        key   = 1'b0;

        // Reset values, then scan order and blink periods through a full frame wrap.
        step();
        step();
        rst = 1'b0;
        repeat (17) step();

        // Live picture update while row 0 is driven: visible on the next edge.
        pic_g = 64'hFF00000000000000;
        step();
        check("live_col_g", col_g, 8'hFF);

        // Clean press: pulse on the 7th edge counting the first sampling edge as 1.
        key      = 1'b1;
        pulse_at = n + 7;
        repeat (12) step();
        key = 1'b0;
        repeat (10) step();

        // Three-cycle glitch alone: no pulse.
        key = 1'b1;
        repeat (3) step();
        key = 1'b0;
        repeat (10) step();

        // Bounce: 1 for 3, 0 for 2, then held; pulse timed from the final rise.
        key = 1'b1;
        repeat (3) step();
        key = 1'b0;
        repeat (2) step();
        key      = 1'b1;
        pulse_at = n + 7;
        repeat (12) step();
        key = 1'b0;
        repeat (10) step();

        // Move to just before the first cycle of row 5.
        guard = 0;
        while (!(((n / SC) % 8 == 5) && (n % SC == 0)) && guard < 40) begin
            step();
            guard++;
        end
        check("reach_idx5", 8'(guard < 40), 8'h01);

        // Start a press, then reset during row 5: the partial debounce is discarded.
        key      = 1'b1;
        pulse_at = -1;
        step();
        check("row_idx5", row, 8'hDF);
        rst = 1'b1;
        step();
        rst      = 1'b0;
        pulse_at = 7;  // key still held: a fresh debounce from the first edge after release
        step();
        check("row_after_rst", row, 8'hFE);
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/matrix_display_core.md
Name: matrix_display_core

Overview:
- Front-end helper block for the 8x8 bicolor LED matrix panel.
- Contains three free-running blink clock dividers (low, mid and high rate), a push-button debouncer that emits a single-cycle press pulse, and a row-scan driver.
- The row-scan driver multiplexes two 64-bit frame buffers (red, green) onto the row/column pins.
- It sits between the level/animation control logic, which supplies the pictures and consumes the blink and press signals, and the board pins.

Parameters:
- DIV_LOW, 1000, period in clk cycles of blink_low; even, >=2.
- DIV_MID, 500, period in clk cycles of blink_mid; even, >=2.
- DIV_HIGH, 250, period in clk cycles of blink_high; even, >=2.
- DEB_CYCLES, 20000, consecutive cycles the synchronized key must differ from the debounced level before that level changes; >=1.
- SCAN_CYCLES, 1000, clk cycles each matrix row is driven; >=2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- key  in  1  raw push-button, active-high, asynchronous to clk.
- picture_r  in  64  red frame.
- picture_g  in  64  green frame.
- key_pulse  out  1  one-cycle pulse per debounced press.
- blink_low  out  1  50% square wave, period DIV_LOW.
- blink_mid  out  1  50% square wave, period DIV_MID.
- blink_high  out  1  50% square wave, period DIV_HIGH.
- row  out  8  row select, active-low, one-hot.
- col_r  out  8  red column drive, active-high.
- col_g  out  8  green column drive, active-high.

Behaviour:
- All outputs are registered.
- Reset values: key_pulse=0, blink_*=0, row=8'hFF, col_r=col_g=0. All internal counters clear, row index=0, debounced level=0, synchronizer flops=0.
- Blink dividers (each independent, divisor D):
  - Counter runs 0..D/2-1.
  - On reaching D/2-1, the counter returns to 0 and the output toggles.
  - First rising edge of the output occurs D/2 cycles after reset release; period is exactly D cycles.
  - The dividers never stop while rst=0.
- Debouncer:
  - key passes through a 2-flop synchronizer.
  - While the synchronized value equals the debounced level, the counter is held at 0.
  - Otherwise the counter increments; when it reaches DEB_CYCLES-1, the debounced level takes the synchronized value and the counter clears.
  - A bounce back to the old level before then clears the counter.
  - key_pulse=1 for exactly one cycle, the cycle after the debounced level goes 0->1.
  - Releases produce no pulse.
  - Clean step latency: key_pulse asserted DEB_CYCLES+3 cycles after the first clk edge that samples key=1.
- Scan driver:
  - A cycle counter runs 0..SCAN_CYCLES-1; at wrap, the row index advances 0..7 and then wraps to 0.
  - Every cycle: row <= ~(8'b1 << idx).
  - col_r <= picture_r[63-8*idx -: 8] and col_g <= picture_g[63-8*idx -: 8]. Byte bit 7 maps to col[7].
  - Row 0 is the top row and takes bits [63:56].
  - The first cycle after reset release drives row=8'hFE with row-0 data.
  - Picture inputs are not latched per frame; a change is visible on the columns one cycle later.
- Reset asserted mid-operation returns everything to the reset values on the next edge. An in-progress debounce count is discarded and no pulse is produced.
- Key input changes and blink wraps in the same cycle are independent; there is no interaction.

Optional Feature:
- Macro GHOST_BLANK_EN.
- Defined: during the first cycle of every row slot (scan counter==0), col_r=col_g=8'h00 while row already selects the new row. This suppresses ghosting. The row data appears from the second cycle of the slot.
- Undefined: the columns carry row data for the whole slot.

Test Plan:
- Blink periods: DIV_LOW=8, DIV_MID=4, DIV_HIGH=2, rst released at cycle 0.
  - blink_low rises at cycle 4 and toggles every 4 cycles.
  - blink_mid toggles every 2 cycles.
  - blink_high toggles every cycle.
- Debounce clean press: DEB_CYCLES=4, key 0->1 held.
  - key_pulse=1 for exactly one cycle, 7 cycles after the first sampling edge.
  - Holding or releasing the key produces no further pulse.
- Debounce bounce: key=1 for 3 cycles, 0 for 2 cycles, then 1 held.
  - Exactly one pulse, timed from the final rise.
  - A 3-cycle glitch alone gives no pulse.
- Scan order: SCAN_CYCLES=2, picture_r=64'h0102040810204080, picture_g=0.
  - row sequence FE,FE,FD,FD,...,7F,7F, then wraps to FE.
  - col_r per row: 01,02,04,08,10,20,40,80; col_g=0.
- Live picture update: change picture_g mid-slot to 64'hFF00000000000000 while idx=0 → col_g=FF on the next cycle.
- Reset mid-scan: rst pulsed at idx=5 → next cycle row=FF, columns 0, blinks 0; after release, row=FE.
  - With GHOST_BLANK_EN defined, the columns read 00 on the first cycle of each slot.
